mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter_rr_arb2.sv | 44 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

    localparam int MEM_DEPTH_DEFAULT = 128;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Master-side command/response bus of mem_arbiter: two request/response
// handshake pairs plus the shared read data and error return.
interface mem_arbiter_if #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [A_SIZE-1:0] req0_addr;
    logic [D_SIZE-1:0] req0_wdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [A_SIZE-1:0] req1_addr;
    logic [D_SIZE-1:0] req1_wdata;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [D_SIZE-1:0] rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_rdata, rsp_err
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant. Grant is combinational; the 1-bit pointer
// names the master that wins a tie and flips to the loser on every accept.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       accept
);

    logic ptr_q, ptr_d;

    // Lone requester wins outright; a tie goes to the pointer owner.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || ptr_q == REQ0)) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end
        accept   = (grant != 2'b00);
        grant_id = grant[1] ? REQ1 : REQ0;
        ptr_d    = ptr_q;
        if (accept) begin
            ptr_d = ~grant_id;
        end
    end

    // Pointer register; comes out of reset favouring master 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the single-port registered-read memory.
// One command in flight at a time.
// Optional: MEM_ARB_ADDR_CHECK_EN rejects addr >= MEM_DEPTH with rsp_err
// and no memory strobe; without it rsp_err stays 0 and all addresses pass.
//
// state | meaning
// IDLE  | arbitrate, assert ready to the winner, latch command on handshake
// CMD   | one-cycle mem_read or mem_write strobe with latched addr/data
// WAIT  | registered read data valid, captured into rsp_rdata
// RESP  | rspN_valid to latched id, held until rspN_ready
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int A_SIZE    = 10,
    parameter int D_SIZE    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic              mem_read,
    output logic              mem_write,
    output logic [A_SIZE-1:0] mem_address,
    output logic [D_SIZE-1:0] mem_data_input,
    input  logic [D_SIZE-1:0] mem_data_output
);

    localparam logic [A_SIZE:0] DEPTH_LIM = (A_SIZE+1)'(MEM_DEPTH);
`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    arb_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [A_SIZE-1:0] addr_q, addr_d;
    logic [D_SIZE-1:0] wdata_q, wdata_d;
    logic [D_SIZE-1:0] rdata_q, rdata_d;
    logic              id_q, id_d;
    logic              err_q, err_d;

    logic [1:0]        grant;
    logic              grant_id;
    logic              accept;
    logic              sel_write;
    logic [A_SIZE-1:0] sel_addr;
    logic [D_SIZE-1:0] sel_wdata;
    logic              addr_bad;
    logic              rsp_done;
    logic [1:0]        rsp_valid;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == IDLE),
        .req      ({bus.req1_valid, bus.req0_valid}),
        .grant    (grant),
        .grant_id (grant_id),
        .accept   (accept)
    );

    assign sel_write = (grant_id == REQ1) ? bus.req1_write : bus.req0_write;
    assign sel_addr  = (grant_id == REQ1) ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = (grant_id == REQ1) ? bus.req1_wdata : bus.req0_wdata;
    assign addr_bad  = CHECK_EN && ({1'b0, sel_addr} >= DEPTH_LIM);
    assign rsp_done  = (id_q == REQ1) ? bus.rsp1_ready : bus.rsp0_ready;

    // Next-state, command latching and per-state strobes.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        id_d      = id_q;
        err_d     = err_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    id_d    = grant_id;
                    rdata_d = '0;
                    err_d   = addr_bad;
                    state_d = addr_bad ? RESP : CMD;
                end
            end
            CMD: begin
                mem_read  = ~write_q;
                mem_write = write_q;
                state_d   = write_q ? RESP : WAIT;
            end
            WAIT: begin
                rdata_d = mem_data_output;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched command/response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            id_q    <= REQ0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_err    = err_q;
    assign mem_address    = addr_q;
    assign mem_data_input = wdata_q;

endmodule
